// File: rtl/demapper_scheduler.sv
// OFDM demapper scheduler: tracks bin/symbol position of the FFT stream, forwards
// only bins inside two programmable bands, and sequences start/stop/symbol-budget runs.
module demapper_scheduler #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FFT_LOG2               = 10
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  input  logic                                  s00_axis_tvalid,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready,
  input  logic                                  ctrl_start,
  input  logic                                  ctrl_stop,
  input  logic [FFT_LOG2-1:0]                   cfg_lo_first,
  input  logic [FFT_LOG2-1:0]                   cfg_lo_last,
  input  logic [FFT_LOG2-1:0]                   cfg_hi_first,
  input  logic [FFT_LOG2-1:0]                   cfg_hi_last,
  input  logic [15:0]                           cfg_num_symbols,
  output logic                                  sts_busy,
  output logic                                  sts_done,
  output logic [15:0]                           sts_symbol_count,
  output logic                                  sts_sync_err
);

  localparam logic [FFT_LOG2-1:0] LAST_BIN = '1;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t state, state_next;

  logic [FFT_LOG2-1:0] lo_first, lo_last, hi_first, hi_last;
  logic [15:0]         num_symbols;
  logic [FFT_LOG2-1:0] bin;
  logic [FFT_LOG2-1:0] last_kept;
  logic [15:0]         count_inc;
  logic                accept, bin_wrap, boundary, budget_hit, keep, start, end_run;

  assign s00_axis_tready = (state != IDLE) && (!m00_axis_tvalid || m00_axis_tready);
  assign accept          = s00_axis_tvalid && s00_axis_tready;
  assign bin_wrap        = (bin == LAST_BIN);
  assign boundary        = accept && (bin_wrap || s00_axis_tlast);
  assign count_inc       = (sts_symbol_count == 16'hFFFF) ? sts_symbol_count
                                                          : sts_symbol_count + 16'd1;
  assign budget_hit      = (num_symbols != 16'd0) && (count_inc == num_symbols);
  // A band whose first index exceeds its last naturally matches no bin.
  assign keep            = ((bin >= lo_first) && (bin <= lo_last)) ||
                           ((bin >= hi_first) && (bin <= hi_last));
  assign last_kept       = (hi_first <= hi_last) ? hi_last : lo_last;
  assign start           = (state == IDLE) && ctrl_start;
  assign sts_busy        = (state != IDLE);

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    end_run    = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (boundary && (budget_hit || ctrl_stop)) begin
          state_next = IDLE;
          end_run    = 1'b1;
        end else if (ctrl_stop) begin
          state_next = STOPPING;
        end
      end
      STOPPING: begin
        if (boundary) begin
          state_next = IDLE;
          end_run    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      lo_first         <= '0;
      lo_last          <= '0;
      hi_first         <= '0;
      hi_last          <= '0;
      num_symbols      <= '0;
      bin              <= '0;
      sts_symbol_count <= '0;
      sts_sync_err     <= 1'b0;
      sts_done         <= 1'b0;
    end else begin
      sts_done <= end_run;
      if (start) begin
        lo_first         <= cfg_lo_first;
        lo_last          <= cfg_lo_last;
        hi_first         <= cfg_hi_first;
        hi_last          <= cfg_hi_last;
        num_symbols      <= cfg_num_symbols;
        bin              <= '0;
        sts_symbol_count <= '0;
        sts_sync_err     <= 1'b0;
      end else if (accept) begin
        // An early input tlast realigns the counter to the next symbol.
        bin <= boundary ? '0 : bin + FFT_LOG2'(1);
        if (boundary) begin
          sts_symbol_count <= count_inc;
        end
        if (s00_axis_tlast && !bin_wrap) begin
          sts_sync_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else if (accept && keep) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tdata  <= s00_axis_tdata;
      m00_axis_tstrb  <= s00_axis_tstrb;
      m00_axis_tlast  <= (bin == last_kept);
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: doc/demapper_scheduler.md
# demapper_scheduler

Symbol-level controller for the OFDM subcarrier demapper path. It takes the post-FFT sample stream (one complex bin per beat, 2^FFT_LOG2 bins per symbol) and tracks bin and symbol position. It keeps only the bins inside two programmable data bands and frames each symbol's kept bins with tlast. It also runs a start/stop/symbol-budget sequence and reports status. It sits between the FFT output and the downstream symbol demodulator.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 32, input sample width
- C_M00_AXIS_TDATA_WIDTH, 32, output sample width; must equal input width
- FFT_LOG2, 10, log2 of bins per symbol (N = 1024)
- s00_axis_aclk  in  1  single clock for all logic
- s00_axis_aresetn  in  1  reset, asynchronous assert, active-low
- s00_axis_tready  out  1  input ready
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  input sample
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  input strobe
- s00_axis_tlast  in  1  input marks the last bin of a symbol
- s00_axis_tvalid  in  1  input valid
- m00_axis_tvalid  out  1  output valid
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  kept sample
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  strobe, passed through
- m00_axis_tlast  out  1  last kept bin of the symbol
- m00_axis_tready  in  1  output ready
- ctrl_start  in  1  one-cycle start pulse
- ctrl_stop  in  1  one-cycle stop request
- cfg_lo_first, cfg_lo_last  in  FFT_LOG2 each  low band, inclusive bin indices (default use 1, 400)
- cfg_hi_first, cfg_hi_last  in  FFT_LOG2 each  high band, inclusive bin indices (default use 623, 1022)
- cfg_num_symbols  in  16  symbols per run; 0 = unlimited
- sts_busy  out  1  state is not IDLE
- sts_done  out  1  one-cycle pulse when a run ends
- sts_symbol_count  out  16  symbols completed in the current or last run
- sts_sync_err  out  1  sticky input-misalignment flag

## Operation
- **States:** IDLE, RUN, STOPPING.
- **IDLE**
  - s00_axis_tready = 0.
  - On ctrl_start: latch all cfg_* inputs; clear bin, sts_symbol_count and sts_sync_err; go to RUN.
  - ctrl_stop is ignored.
- **Input accept:** a beat is accepted when s00_axis_tvalid && s00_axis_tready.
- **Bin and symbol counting**
  - The bin counter (FFT_LOG2 bits) increments on each accepted beat and wraps N-1 -> 0.
  - The wrap marks the symbol boundary: sts_symbol_count increments, saturating at 0xFFFF.
- **Keep rule**
  - keep = (lo_first <= bin <= lo_last) || (hi_first <= bin <= hi_last).
  - A band with first > last is empty.
  - Kept beats load the output register. Dropped beats are consumed and discarded.
- **Output tlast:** asserted on the kept beat where bin == last_kept, with last_kept = hi_last if the hi band is non-empty, else lo_last.
- **Input ready:** in RUN/STOPPING, s00_axis_tready = !m00_axis_tvalid || m00_axis_tready. Dropped beats therefore still respect output backpressure, so no reordering is possible.
- **Sync check**
  - An accepted s00_axis_tlast with bin != N-1 sets sts_sync_err (sticky).
  - The bin counter is then forced to 0 for the next beat and the symbol count still increments.
- **Run end**
  - In RUN, the symbol boundary where the count reaches cfg_num_symbols (non-zero) ends the run.
  - ctrl_stop in RUN moves to STOPPING, which continues normally until the next symbol boundary.
  - At the end of the run: go to IDLE and pulse sts_done. The output register still drains.
- **Restart:** ctrl_start in RUN/STOPPING is ignored.

## Timing
- **Latency:** 1 cycle from accept to m00_axis_tvalid. Single output register with full throughput: 1 beat/cycle when m00_axis_tready = 1.
- **Output stability:** m00_axis_tdata/tstrb/tlast are held stable while tvalid && !tready.
- **Reset values:** all outputs 0; state IDLE; bin 0; latched config 0.
- **Reset mid-run:** asynchronous clear of state, counters and output valid. Any in-flight beat is lost.
- **Boundary conditions**
  - ctrl_stop on the same cycle as the bin N-1 accept ends the run at that boundary.
  - Budget reached and stop on the same cycle: a single sts_done.
  - ctrl_start and ctrl_stop together in IDLE: start wins.
  - sts_done asserts the cycle after the final accept.
  - sts_busy falls the same cycle as sts_done.
- **Start-to-accept:** the first input accept is possible the cycle after the ctrl_start pulse.

## Test plan
- Default bands (1..400, 623..1022), cfg_num_symbols = 2, continuous input with tdata = bin index, tready = 1 -> output:
  - 800 beats per symbol: data 1..400 then 623..1022.
  - tlast only on 1022.
  - sts_symbol_count = 2, one sts_done, then tready = 0.
- Same run with m00_axis_tready toggling 1/0 -> identical output sequence, no loss or duplication, data held while stalled.
- hi band empty (hi_first = 5, hi_last = 4), lo = 10..20 -> 11 beats per symbol, tlast on bin 20.
- cfg_num_symbols = 0, ctrl_stop at bin 300 of symbol 3 -> symbol 3 completes (all 800 kept beats), run ends with sts_symbol_count = 4.
- Input tlast injected at bin 511 -> sts_sync_err = 1; the next beat is treated as bin 0 and the keep pattern restarts; the flag stays set until the next ctrl_start.
- Reset asserted mid-symbol with output stalled -> all outputs 0 immediately; a fresh start produces a clean first symbol.
